// File: rtl/counter_run_ctrl.sv
// counter_run_ctrl - RUN/PAUSE/DONE run controller and tick prescaler for the mod-15/mod-115 BCD counter.
// Optional feature: AUTO_RELOAD_EN (DONE reloads to RUN after DONE_HOLD ticks).
module counter_run_ctrl #(
    parameter int TICK_DIV  = 25000000,
    parameter int DONE_HOLD = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_start,
    input  logic       key_clear,
    input  logic       m_req,
    input  logic       tc,
    output logic       clk1,
    output logic       en,
    output logic       m,
    output logic       clr_n,
    output logic [1:0] state,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [26:0] PRESC_TOP = 27'(TICK_DIV - 1);

    state_t      cur;
    state_t      nxt;
    logic [26:0] presc;
    logic [26:0] presc_nxt;
    logic        clk1_nxt;
    logic        clr_req;
    logic        running;

`ifdef AUTO_RELOAD_EN
    localparam int HW = $clog2(DONE_HOLD + 1);
    logic [HW-1:0] hold;
    logic [HW-1:0] hold_nxt;
    logic          reload;

    assign reload  = clk1 && (hold == HW'(DONE_HOLD - 1));
    assign running = (cur == RUN) || (cur == DONE);
`else
    assign running = (cur == RUN);
`endif

    always_comb begin
        nxt     = cur;
        clr_req = 1'b0;
        case (cur)
            IDLE:  if (key_start) nxt = RUN;
            RUN: begin
                if (tc)             nxt = DONE;
                else if (key_start) nxt = PAUSE;
            end
            PAUSE: if (key_start) nxt = RUN;
            DONE: begin
                if (key_start) begin
                    nxt     = IDLE;
                    clr_req = 1'b1;
                end
`ifdef AUTO_RELOAD_EN
                else if (reload) begin
                    nxt     = RUN;
                    clr_req = 1'b1;
                end
`endif
            end
            default: nxt = IDLE;
        endcase
        if (key_clear) begin
            nxt     = IDLE;
            clr_req = 1'b1;
        end
    end

    // The prescaler only advances while the state stays put, so no tick can
    // coincide with leaving RUN and PAUSE keeps the partial count.
    always_comb begin
        presc_nxt = presc;
        clk1_nxt  = 1'b0;
        if (nxt == IDLE || (cur != RUN && nxt == RUN && cur != PAUSE)) begin
            presc_nxt = '0;
        end else if (running && cur == nxt) begin
            presc_nxt = (presc == PRESC_TOP) ? 27'd0 : presc + 27'd1;
            clk1_nxt  = (presc_nxt == PRESC_TOP);
        end
    end

`ifdef AUTO_RELOAD_EN
    always_comb begin
        hold_nxt = hold;
        if (nxt != DONE)
            hold_nxt = '0;
        else if (cur == DONE && clk1)
            hold_nxt = hold + HW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) hold <= '0;
        else     hold <= hold_nxt;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur   <= IDLE;
            presc <= '0;
            clk1  <= 1'b0;
            en    <= 1'b0;
            m     <= 1'b1;
            clr_n <= 1'b0;
            done  <= 1'b0;
        end else begin
            cur   <= nxt;
            presc <= presc_nxt;
            clk1  <= clk1_nxt;
            en    <= (nxt == RUN);
            clr_n <= ~clr_req;
            done  <= (cur == RUN) && (nxt == DONE);
            if (cur == IDLE && nxt == RUN)
                m <= m_req;
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_counter_run_ctrl.sv
// tb/tb_counter_run_ctrl.sv - directed table-driven bench for counter_run_ctrl (TICK_DIV=2, DONE_HOLD=3).
module tb_counter_run_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_start = 1'b0;
    logic       key_clear = 1'b0;
    logic       m_req = 1'b1;
    logic       tc = 1'b0;
    logic       clk1;
    logic       en;
    logic       m;
    logic       clr_n;
    logic [1:0] state;
    logic       done;

    int n_cmp = 0;
    int n_bad = 0;

    counter_run_ctrl #(.TICK_DIV(2), .DONE_HOLD(3)) dut (
        .clk(clk), .rst(rst), .key_start(key_start), .key_clear(key_clear),
        .m_req(m_req), .tc(tc), .clk1(clk1), .en(en), .m(m), .clr_n(clr_n),
        .state(state), .done(done)
    );

    always #5 clk = ~clk;

    // Observation word: {state[1:0], en, m, clk1, clr_n, done}
    typedef struct {
        logic       ks;
        logic       kc;
        logic       mr;
        logic       t;
        logic [6:0] exp;
    } vec_t;

    vec_t vt[24];

    task automatic check(input string name, input logic [6:0] exp);
        logic [6:0] obs;
        obs = {state, en, m, clk1, clr_n, done};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, obs, exp);
        end
    endtask

    task automatic step(input logic ks, input logic kc, input logic mr, input logic t);
        key_start = ks;
        key_clear = kc;
        m_req     = mr;
        tc        = t;
        @(posedge clk);
        #1;
        key_start = 1'b0;
        key_clear = 1'b0;
        tc        = 1'b0;
    endtask

    initial begin
        int ticks;
        int cyc;
        vt[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 7'b00_0_1_0_1_0};
        vt[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 7'b00_0_1_0_1_0};
        vt[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 7'b01_1_1_0_1_0};
        vt[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 7'b01_1_1_1_1_0};
        vt[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 7'b01_1_1_0_1_0};
        vt[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 7'b01_1_1_1_1_0};
        vt[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 7'b01_1_1_0_1_0};
        vt[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 7'b10_0_1_0_1_0};
        vt[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 7'b10_0_1_0_1_0};
        vt[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 7'b01_1_1_0_1_0};
        vt[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 7'b01_1_1_1_1_0};
        vt[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 7'b01_1_1_0_1_0};
        vt[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 7'b11_0_1_0_1_1};
        vt[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 7'b00_0_1_0_0_0};
        vt[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 7'b00_0_1_0_1_0};
        vt[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 7'b01_1_0_0_1_0};
        vt[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 7'b01_1_0_1_1_0};
        vt[17] = '{1'b0, 1'b1, 1'b1, 1'b1, 7'b00_0_0_0_0_0};
        vt[18] = '{1'b0, 1'b0, 1'b1, 1'b0, 7'b00_0_0_0_1_0};
        vt[19] = '{1'b1, 1'b0, 1'b1, 1'b0, 7'b01_1_1_0_1_0};
        vt[20] = '{1'b0, 1'b1, 1'b1, 1'b0, 7'b00_0_1_0_0_0};
        vt[21] = '{1'b0, 1'b1, 1'b1, 1'b0, 7'b00_0_1_0_0_0};
        vt[22] = '{1'b0, 1'b0, 1'b1, 1'b0, 7'b00_0_1_0_1_0};
        vt[23] = '{1'b0, 1'b0, 1'b1, 1'b1, 7'b00_0_1_0_1_0};

        #12;
        check("reset_values", 7'b00_0_1_0_0_0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_release_clr_low", 7'b00_0_1_0_0_0);

        for (int i = 0; i < 24; i++) begin
            step(vt[i].ks, vt[i].kc, vt[i].mr, vt[i].t);
            check($sformatf("vec%0d", i), vt[i].exp);
        end

        // Asynchronous reset in the middle of an issued tick
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("pre_async_tick", 7'b01_1_1_1_1_0);
        rst = 1'b1;
        #1;
        check("async_reset_immediate", 7'b00_0_1_0_0_0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("async_reset_held", 7'b00_0_1_0_0_0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("async_release_clr_high", 7'b00_0_1_0_1_0);

        // DONE dwell: reload after three ticks, or a permanent stop
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("done_seq_run", 7'b01_1_1_0_1_0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check("done_seq_enter", 7'b11_0_1_0_1_1);
        ticks = 0;
        cyc   = 0;
`ifdef AUTO_RELOAD_EN
        while (state == 2'b11 && cyc < 20) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            if (state == 2'b11 && clk1) ticks++;
            cyc++;
        end
        n_cmp++;
        if (ticks != 3) begin
            n_bad++;
            $display("FAIL reload_tick_count: got %0d expected 3", ticks);
        end
        check("reload_entry", 7'b01_1_1_0_0_0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("reload_first_tick", 7'b01_1_1_1_1_0);
`else
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            if (clk1) ticks++;
            cyc++;
        end
        n_cmp++;
        if (ticks != 0) begin
            n_bad++;
            $display("FAIL done_no_ticks: got %0d expected 0", ticks);
        end
        check("done_stays", 7'b11_0_1_0_1_0);
`endif
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("final_clear", 7'b00_0_1_0_0_0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
